// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

// File: rtl/md_latency_fsm.sv
// Tracks how long a multi-cycle MUL/DIV has occupied E and requests E to hold
// until it has been there MD_LATENCY cycles. Frozen while the memory stage stalls.
module md_latency_fsm
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic freeze_i,
   output logic hold_o,
   output logic busy_o
);

   localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
   localparam logic MULTI = (MD_LATENCY > 1);
   // First BUSY cycle is already the op's second cycle in E.
   localparam logic [CW-1:0] CNT_INIT = (MD_LATENCY > 1) ? CW'(MD_LATENCY - 2) : '0;

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_o  = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start_i && MULTI) begin
               hold_o = 1'b1;
               if (!freeze_i) begin
                  state_d = MD_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         MD_BUSY: begin
            if (cnt_q != '0) begin
               hold_o = 1'b1;
               if (!freeze_i) cnt_d = cnt_q - CW'(1);
            end else if (!freeze_i) begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, per-stage
// stall/flush with multi-cycle MUL/DIV and D-mem wait states, and a stall-cycle counter.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [REG_ADDR_W-1:0] Rs1D_i,
   input  logic [REG_ADDR_W-1:0] Rs2D_i,
   input  logic [6:0]            OpD_i,
   input  logic [REG_ADDR_W-1:0] Rs1E_i,
   input  logic [REG_ADDR_W-1:0] Rs2E_i,
   input  logic [REG_ADDR_W-1:0] RdE_i,
   input  logic                  ResultSrcE_i,
   input  logic                  PCSrcE_i,
   input  logic                  MdStartE_i,
   input  logic [REG_ADDR_W-1:0] RdM_i,
   input  logic                  RegWriteM_i,
   input  logic                  DMemStallM_i,
   input  logic [REG_ADDR_W-1:0] RdW_i,
   input  logic                  RegWriteW_i,
   output logic                  StallF_o,
   output logic                  StallD_o,
   output logic                  StallE_o,
   output logic                  StallM_o,
   output logic                  FlushD_o,
   output logic                  FlushE_o,
   output logic                  FlushM_o,
   output logic                  FlushW_o,
   output logic [1:0]            ForwardAE_o,
   output logic [1:0]            ForwardBE_o,
   output logic                  MdBusy_o,
   output logic [CNT_W-1:0]      StallCount_o
);

   logic             md_hold;
   logic             lw_stall;
   logic             jalr_stall;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   function automatic fwd_sel_e fwd_sel(input logic [REG_ADDR_W-1:0] rs);
      if (rs != '0 && RegWriteM_i && rs == RdM_i)      return FWD_M;
      else if (rs != '0 && RegWriteW_i && rs == RdW_i) return FWD_W;
      else                                             return FWD_NONE;
   endfunction

   assign ForwardAE_o = fwd_sel(Rs1E_i);
   assign ForwardBE_o = fwd_sel(Rs2E_i);

   md_latency_fsm #(.MD_LATENCY(MD_LATENCY)) u_md_fsm (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (MdStartE_i),
      .freeze_i (DMemStallM_i),
      .hold_o   (md_hold),
      .busy_o   (MdBusy_o)
   );

   assign lw_stall   = ResultSrcE_i && (RdE_i != '0) &&
                       ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));
   // JALR reads rs1 in D, so a producer still in E (load) or M cannot be forwarded in time.
   assign jalr_stall = (OpD_i == OP_JALR) &&
                       ((ResultSrcE_i && (RdE_i != '0) && (Rs1D_i == RdE_i)) ||
                        (RegWriteM_i && (RdM_i != '0) && (Rs1D_i == RdM_i)));

   always_comb begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushM_o = 1'b0;
      FlushW_o = 1'b0;
      if (DMemStallM_i) begin
         {StallF_o, StallD_o, StallE_o, StallM_o} = 4'b1111;
         FlushW_o = 1'b1;
      end else if (md_hold) begin
         {StallF_o, StallD_o, StallE_o} = 3'b111;
         FlushM_o = 1'b1;
      end else if (lw_stall || jalr_stall) begin
         {StallF_o, StallD_o} = 2'b11;
         FlushE_o = 1'b1;
         FlushD_o = PCSrcE_i;
      end else begin
         FlushD_o = PCSrcE_i;
         FlushE_o = PCSrcE_i;
      end
   end

   assign stall_cnt_d = (StallF_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios plus randomized
// traffic against an occupancy-based reference model.
module tb_hazard_unit_mc;

   localparam int RW  = 5;
   localparam int LAT = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [RW-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
   logic [6:0]    OpD_i;
   logic          ResultSrcE_i, PCSrcE_i, MdStartE_i, RegWriteM_i, DMemStallM_i, RegWriteW_i;
   logic          StallF_o, StallD_o, StallE_o, StallM_o;
   logic          FlushD_o, FlushE_o, FlushM_o, FlushW_o;
   logic [1:0]    ForwardAE_o, ForwardBE_o;
   logic          MdBusy_o;
   logic [CW-1:0] StallCount_o;

   int n_tests = 0;
   int n_fail  = 0;
   int m_e;    // cycles the current MUL/DIV has already spent in E (0 = none)
   int m_cnt;  // expected stall-cycle count

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_ADDR_W(RW), .MD_LATENCY(LAT), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .OpD_i(OpD_i),
      .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i), .RdE_i(RdE_i),
      .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i), .MdStartE_i(MdStartE_i),
      .RdM_i(RdM_i), .RegWriteM_i(RegWriteM_i), .DMemStallM_i(DMemStallM_i),
      .RdW_i(RdW_i), .RegWriteW_i(RegWriteW_i),
      .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
      .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushM_o(FlushM_o), .FlushW_o(FlushW_o),
      .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
      .MdBusy_o(MdBusy_o), .StallCount_o(StallCount_o)
   );

   function automatic logic [12:0] dut_vec();
      return {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushM_o, FlushW_o,
              ForwardAE_o, ForwardBE_o, MdBusy_o};
   endfunction

   function automatic logic [1:0] mfwd(input logic [RW-1:0] rs);
      if (rs != 0 && RegWriteM_i && rs == RdM_i) return 2'b10;
      if (rs != 0 && RegWriteW_i && rs == RdW_i) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [12:0] model_vec();
      logic hold, lw, jalr;
      logic [7:0] s;
      hold = (m_e > 0 || MdStartE_i) && (m_e + 1 < LAT);
      lw   = ResultSrcE_i && RdE_i != 0 && (Rs1D_i == RdE_i || Rs2D_i == RdE_i);
      jalr = OpD_i == 7'b1100111 &&
             ((ResultSrcE_i && RdE_i != 0 && Rs1D_i == RdE_i) ||
              (RegWriteM_i && RdM_i != 0 && Rs1D_i == RdM_i));
      if (DMemStallM_i)    s = 8'b1111_0001;
      else if (hold)       s = 8'b1110_0010;
      else if (lw || jalr) s = {4'b1100, PCSrcE_i, 1'b1, 2'b00};
      else                 s = {4'b0000, PCSrcE_i, PCSrcE_i, 2'b00};
      return {s, mfwd(Rs1E_i), mfwd(Rs2E_i), m_e > 0};
   endfunction

   task automatic model_step();
      logic stall_f;
      stall_f = model_vec()[12];
      if (!rst_ni) begin
         m_e = 0; m_cnt = 0;
      end else begin
         if (stall_f && m_cnt < (1 << CW) - 1) m_cnt++;
         if (!DMemStallM_i && (m_e > 0 || (MdStartE_i && LAT > 1)))
            m_e = (m_e + 1 == LAT) ? 0 : m_e + 1;
      end
   endtask

   task automatic zero_inputs();
      {Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i} = '0;
      OpD_i = 7'b0110011;
      {ResultSrcE_i, PCSrcE_i, MdStartE_i, RegWriteM_i, DMemStallM_i, RegWriteW_i} = '0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      zero_inputs();
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if (dut_vec() !== 13'b0) begin
         n_fail++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 13'b0);
      end
      n_tests++;
      if (StallCount_o !== 4'd0) begin
         n_fail++; $display("FAIL reset_count got=%0d exp=0", StallCount_o);
      end
   endtask

   task automatic test_forwarding();
      Rs1E_i = 5; RdM_i = 5; RegWriteM_i = 1; RdW_i = 5; RegWriteW_i = 1; #1;
      n_tests++;
      if (ForwardAE_o !== 2'b10) begin
         n_fail++; $display("FAIL fwd_m_wins got=%b exp=10", ForwardAE_o);
      end
      Rs2E_i = 5; RegWriteM_i = 0; #1;
      n_tests++;
      if (ForwardBE_o !== 2'b01) begin
         n_fail++; $display("FAIL fwd_w got=%b exp=01", ForwardBE_o);
      end
      Rs1E_i = 0; RdM_i = 0; RegWriteM_i = 1; RdW_i = 0; #1;
      n_tests++;
      if (ForwardAE_o !== 2'b00) begin
         n_fail++; $display("FAIL fwd_x0 got=%b exp=00", ForwardAE_o);
      end
      zero_inputs();
   endtask

   task automatic test_load_use();
      ResultSrcE_i = 1; RdE_i = 7; Rs2D_i = 7; #1;
      n_tests++;
      if ({StallF_o, StallD_o, FlushE_o, StallE_o, FlushD_o} !== 5'b11100) begin
         n_fail++; $display("FAIL load_use got=%b exp=11100", {StallF_o, StallD_o, FlushE_o, StallE_o, FlushD_o});
      end
      RdE_i = 0; Rs2D_i = 0; #1;
      n_tests++;
      if ({StallF_o, StallD_o, FlushE_o} !== 3'b000) begin
         n_fail++; $display("FAIL load_x0 got=%b exp=000", {StallF_o, StallD_o, FlushE_o});
      end
      zero_inputs();
      OpD_i = 7'b1100111; RegWriteM_i = 1; RdM_i = 3; Rs1D_i = 3; #1;
      n_tests++;
      if ({StallF_o, StallD_o, FlushE_o} !== 3'b111) begin
         n_fail++; $display("FAIL jalr_m got=%b exp=111", {StallF_o, StallD_o, FlushE_o});
      end
      zero_inputs();
   endtask

   task automatic test_pcsrc_lwstall();
      ResultSrcE_i = 1; RdE_i = 9; Rs1D_i = 9; PCSrcE_i = 1; #1;
      n_tests++;
      if ({StallF_o, StallD_o, FlushD_o, FlushE_o, StallE_o} !== 5'b11110) begin
         n_fail++; $display("FAIL pcsrc_lw got=%b exp=11110", {StallF_o, StallD_o, FlushD_o, FlushE_o, StallE_o});
      end
      zero_inputs();
   endtask

   task automatic test_md_latency();
      logic [4:0] exp;
      do_reset();
      MdStartE_i = 1;
      for (int k = 1; k <= LAT; k++) begin
         #1;
         exp = {{4{k < LAT}}, k > 1};
         n_tests++;
         if ({StallF_o, StallD_o, StallE_o, FlushM_o, MdBusy_o} !== exp) begin
            n_fail++; $display("FAIL md_cycle%0d got=%b exp=%b", k,
                               {StallF_o, StallD_o, StallE_o, FlushM_o, MdBusy_o}, exp);
         end
         @(negedge clk);
      end
      zero_inputs(); #1;
      n_tests++;
      if (MdBusy_o !== 1'b0) begin
         n_fail++; $display("FAIL md_done got=%b exp=0", MdBusy_o);
      end
   endtask

   task automatic test_memstall_in_busy();
      logic [5:0] memv;
      logic [5:0] exp;
      memv = 6'b000110;
      do_reset();
      MdStartE_i = 1;
      for (int k = 0; k < 6; k++) begin
         DMemStallM_i = memv[k];
         #1;
         exp = {k != 5, memv[k], memv[k], !memv[k] && k != 5, k > 0, 1'b1};
         n_tests++;
         if ({StallE_o, StallM_o, FlushW_o, FlushM_o, MdBusy_o, StallF_o | (k == 5)} !== exp) begin
            n_fail++; $display("FAIL memstall_cycle%0d got=%b exp=%b", k,
                               {StallE_o, StallM_o, FlushW_o, FlushM_o, MdBusy_o, StallF_o | (k == 5)}, exp);
         end
         @(negedge clk);
      end
      zero_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      ResultSrcE_i = 1; RdE_i = 4; Rs1D_i = 4;
      repeat (5) @(negedge clk);
      #1;
      n_tests++;
      if (StallCount_o !== 4'd5) begin
         n_fail++; $display("FAIL count5 got=%0d exp=5", StallCount_o);
      end
      repeat (20) @(negedge clk);
      #1;
      n_tests++;
      if (StallCount_o !== 4'd15) begin
         n_fail++; $display("FAIL count_sat got=%0d exp=15", StallCount_o);
      end
      zero_inputs();
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      MdStartE_i = 1;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (MdBusy_o !== 1'b1) begin
         n_fail++; $display("FAIL midbusy_pre got=%b exp=1", MdBusy_o);
      end
      rst_ni = 0;
      @(negedge clk);
      rst_ni = 1; zero_inputs(); #1;
      n_tests++;
      if ({MdBusy_o, StallF_o, StallD_o, StallE_o, StallM_o, StallCount_o} !== 9'b0) begin
         n_fail++; $display("FAIL midbusy_reset got=%b exp=0",
                            {MdBusy_o, StallF_o, StallD_o, StallE_o, StallM_o, StallCount_o});
      end
   endtask

   task automatic test_random();
      logic [12:0] exp;
      do_reset();
      m_e = 0; m_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         rst_ni       = ($urandom_range(0, 39) != 0);
         Rs1D_i       = RW'($urandom_range(0, 3));
         Rs2D_i       = RW'($urandom_range(0, 3));
         Rs1E_i       = RW'($urandom_range(0, 3));
         Rs2E_i       = RW'($urandom_range(0, 3));
         RdE_i        = RW'($urandom_range(0, 3));
         RdM_i        = RW'($urandom_range(0, 3));
         RdW_i        = RW'($urandom_range(0, 3));
         OpD_i        = ($urandom_range(0, 2) == 0) ? 7'b1100111 : 7'($urandom);
         ResultSrcE_i = ($urandom_range(0, 3) == 0);
         PCSrcE_i     = ($urandom_range(0, 4) == 0);
         MdStartE_i   = ($urandom_range(0, 2) == 0);
         RegWriteM_i  = $urandom_range(0, 1);
         RegWriteW_i  = $urandom_range(0, 1);
         DMemStallM_i = ($urandom_range(0, 4) == 0);
         #1;
         exp = model_vec();
         n_tests++;
         if (dut_vec() !== exp || StallCount_o !== CW'(m_cnt)) begin
            n_fail++; $display("FAIL random_cycle%0d got=%b/%0d exp=%b/%0d", i,
                               dut_vec(), StallCount_o, exp, m_cnt);
         end
         model_step();
         @(negedge clk);
      end
      zero_inputs();
   endtask

   initial begin
      rst_ni = 1'b0;
      zero_inputs();
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use();
      test_pcsrc_lwstall();
      test_md_latency();
      test_memstall_in_busy();
      test_saturation();
      test_reset_mid_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
